// File: rtl/ex_mdu_pkg.sv
// Shared definitions for the ex_mdu multiply/divide unit: op codes, FSM states
// and operand-signedness helpers.
package ex_mdu_pkg;

    localparam int MDU_XLEN = 32;

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } mdu_state_t;

    function automatic logic f_rs1_signed(input logic [2:0] op);
        return (op != OP_MULHU) && (op != OP_DIVU) && (op != OP_REMU);
    endfunction

    function automatic logic f_rs2_signed(input logic [2:0] op);
        return (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/ex_mdu_div_step.sv
// One restoring-division iteration on unsigned magnitudes: shift the next
// dividend bit into the partial remainder and subtract the divisor if it fits.
module ex_mdu_div_step
    import ex_mdu_pkg::*;
#(
    parameter int XLEN = MDU_XLEN
) (
    input  logic [XLEN-1:0] i_rem,
    input  logic [XLEN-1:0] i_quo,
    input  logic [XLEN-1:0] i_div,
    output logic [XLEN-1:0] o_rem,
    output logic [XLEN-1:0] o_quo
);

    logic [XLEN:0] w_shifted;
    logic [XLEN:0] w_diff;

    // Trial subtraction; a set MSB of the difference means the divisor did not fit
    always_comb begin
        w_shifted = {i_rem, i_quo[XLEN-1]};
        w_diff    = w_shifted - {1'b0, i_div};
        if (w_diff[XLEN]) begin
            o_rem = w_shifted[XLEN-1:0];
            o_quo = {i_quo[XLEN-2:0], 1'b0};
        end else begin
            o_rem = w_diff[XLEN-1:0];
            o_quo = {i_quo[XLEN-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/ex_mdu.sv
// Iterative RV M-extension multiply/divide unit for the EX stage.
// Optional MDU_EARLY_OUT_EN: trivial operands (zero multiply, divide by zero, signed overflow) finish in one cycle.
module ex_mdu
    import ex_mdu_pkg::*;
#(
    parameter int XLEN     = MDU_XLEN,
    parameter int MUL_STEP = 1,
    parameter int REG_AW   = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [2:0]        op_i,
    input  logic [XLEN-1:0]   r1_data_i,
    input  logic [XLEN-1:0]   r2_data_i,
    input  logic [REG_AW-1:0] w_addr_i,
    input  logic              flush_i,
    output logic              stall_req_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              w_enable_o,
    output logic [REG_AW-1:0] w_addr_o,
    output logic [XLEN-1:0]   w_data_o
);

    localparam int CNT_W = $clog2(XLEN + 1);
    localparam int SUM_W = XLEN + MUL_STEP;
    localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(XLEN / MUL_STEP - 1);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]  ZERO     = {XLEN{1'b0}};
    localparam logic [XLEN-1:0]  ONES     = {XLEN{1'b1}};
    localparam logic [XLEN-1:0]  INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

    mdu_state_t        r_state;
    mdu_state_t        w_next_state;
    logic [2:0]        r_op;
    logic [REG_AW-1:0] r_addr;
    logic [CNT_W-1:0]  r_cnt;
    logic [XLEN-1:0]   r_hi;
    logic [XLEN-1:0]   r_lo;
    logic [XLEN-1:0]   r_b;
    logic [XLEN-1:0]   r_dividend;
    logic [XLEN-1:0]   r_result;
    logic              r_neg_q;
    logic              r_neg_r;
    logic              r_dz;
    logic              r_ovf;

    logic              w_accept;
    logic              w_last;
    logic              w_neg_a;
    logic              w_neg_b;
    logic              w_dz;
    logic              w_ovf;
    logic              w_early;
    logic [XLEN-1:0]   w_mag_a;
    logic [XLEN-1:0]   w_mag_b;
    logic [SUM_W-1:0]  w_mul_sum;
    logic [XLEN-1:0]   w_mul_hi;
    logic [XLEN-1:0]   w_mul_lo;
    logic [XLEN-1:0]   w_div_rem;
    logic [XLEN-1:0]   w_div_quo;

    // Signs the magnitudes and applies the divide special cases
    function automatic logic [XLEN-1:0] f_result(
        input logic [2:0]      op,
        input logic [XLEN-1:0] hi,
        input logic [XLEN-1:0] lo,
        input logic            neg_q,
        input logic            neg_r,
        input logic            dz,
        input logic            ovf,
        input logic [XLEN-1:0] dividend
    );
        logic [2*XLEN-1:0] prod;
        logic [XLEN-1:0]   quo;
        logic [XLEN-1:0]   rem;
        logic [XLEN-1:0]   res;
        prod = neg_q ? -{hi, lo} : {hi, lo};
        quo  = dz ? ONES : (ovf ? dividend : (neg_q ? -lo : lo));
        rem  = dz ? dividend : (ovf ? ZERO : (neg_r ? -hi : hi));
        case (op)
            OP_MUL:                        res = prod[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  res = prod[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:               res = quo;
            OP_REM, OP_REMU:               res = rem;
            default:                       res = ZERO;
        endcase
        return res;
    endfunction

    // Operand decode: signs, magnitudes and special-case detection
    always_comb begin
        w_neg_a = f_rs1_signed(op_i) & r1_data_i[XLEN-1];
        w_neg_b = f_rs2_signed(op_i) & r2_data_i[XLEN-1];
        w_mag_a = w_neg_a ? -r1_data_i : r1_data_i;
        w_mag_b = w_neg_b ? -r2_data_i : r2_data_i;
        w_dz    = (r2_data_i == ZERO);
        w_ovf   = op_i[2] & f_rs1_signed(op_i) & (r1_data_i == INT_MIN) & (r2_data_i == ONES);
`ifdef MDU_EARLY_OUT_EN
        w_early = op_i[2] ? (w_dz | w_ovf) : ((r1_data_i == ZERO) | (r2_data_i == ZERO));
`else
        w_early = 1'b0;
`endif
        w_accept = start_i & ((r_state == S_IDLE) | (r_state == S_DONE)) & ~flush_i;
        w_last   = (r_state == S_MUL) ? (r_cnt == MUL_LAST) : (r_cnt == DIV_LAST);
    end

    // Shift-add multiply: add MUL_STEP multiplier bits worth of multiplicand, then shift right
    always_comb begin
        w_mul_sum = {{MUL_STEP{1'b0}}, r_hi};
        for (int k = 0; k < MUL_STEP; k++) begin
            w_mul_sum = w_mul_sum + (r_lo[k] ? (SUM_W'(r_b) << k) : {SUM_W{1'b0}});
        end
        w_mul_hi = w_mul_sum[SUM_W-1:MUL_STEP];
        w_mul_lo = {w_mul_sum[MUL_STEP-1:0], r_lo[XLEN-1:MUL_STEP]};
    end

    ex_mdu_div_step #(
        .XLEN (XLEN)
    ) u_div_step (
        .i_rem (r_hi),
        .i_quo (r_lo),
        .i_div (r_b),
        .o_rem (w_div_rem),
        .o_quo (w_div_quo)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state logic; flush wins over start
    always_comb begin
        w_next_state = r_state;
        if (flush_i) begin
            w_next_state = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (!start_i) begin
                        w_next_state = S_IDLE;
                    end else if (w_early) begin
                        w_next_state = S_DONE;
                    end else if (op_i[2]) begin
                        w_next_state = S_DIV;
                    end else begin
                        w_next_state = S_MUL;
                    end
                end
                S_MUL, S_DIV: begin
                    if (w_last) begin
                        w_next_state = S_DONE;
                    end else begin
                        w_next_state = r_state;
                    end
                end
                default: w_next_state = S_IDLE;
            endcase
        end
    end

    // Datapath: {r_hi, r_lo} is the product accumulator for MUL and {remainder, quotient} for DIV
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op       <= 3'd0;
            r_addr     <= {REG_AW{1'b0}};
            r_cnt      <= {CNT_W{1'b0}};
            r_hi       <= ZERO;
            r_lo       <= ZERO;
            r_b        <= ZERO;
            r_dividend <= ZERO;
            r_result   <= ZERO;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_dz       <= 1'b0;
            r_ovf      <= 1'b0;
        end else if (w_accept) begin
            r_op       <= op_i;
            r_addr     <= w_addr_i;
            r_cnt      <= {CNT_W{1'b0}};
            r_hi       <= ZERO;
            r_lo       <= op_i[2] ? w_mag_a : w_mag_b;
            r_b        <= op_i[2] ? w_mag_b : w_mag_a;
            r_dividend <= r1_data_i;
            r_neg_q    <= w_neg_a ^ w_neg_b;
            r_neg_r    <= w_neg_a;
            r_dz       <= w_dz;
            r_ovf      <= w_ovf;
            if (w_early) begin
                r_result <= f_result(op_i, ZERO, ZERO, w_neg_a ^ w_neg_b, w_neg_a,
                                     w_dz, w_ovf, r1_data_i);
            end
        end else if (r_state == S_MUL) begin
            r_hi  <= w_mul_hi;
            r_lo  <= w_mul_lo;
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_last) begin
                r_result <= f_result(r_op, w_mul_hi, w_mul_lo, r_neg_q, r_neg_r,
                                     r_dz, r_ovf, r_dividend);
            end
        end else if (r_state == S_DIV) begin
            r_hi  <= w_div_rem;
            r_lo  <= w_div_quo;
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_last) begin
                r_result <= f_result(r_op, w_div_rem, w_div_quo, r_neg_q, r_neg_r,
                                     r_dz, r_ovf, r_dividend);
            end
        end
    end

    assign busy_o      = (r_state == S_MUL) | (r_state == S_DIV);
    assign done_o      = (r_state == S_DONE);
    assign w_enable_o  = done_o & (r_addr != {REG_AW{1'b0}});
    assign w_addr_o    = done_o ? r_addr : {REG_AW{1'b0}};
    assign w_data_o    = w_enable_o ? r_result : ZERO;
    assign stall_req_o = (start_i & ((r_state == S_IDLE) | (r_state == S_DONE))) | busy_o;

endmodule

// File: tb/tb_ex_mdu.sv
// Scoreboard bench for ex_mdu (XLEN=32, MUL_STEP=1): stimulus pushes expected
// write-backs, a monitor pops them whenever done_o is seen.
module tb_ex_mdu;

    localparam logic [2:0] MUL = 3'd0, MULH = 3'd1, MULHSU = 3'd2, MULHU = 3'd3;
    localparam logic [2:0] DIV = 3'd4, DIVU = 3'd5, REM = 3'd6, REMU = 3'd7;
`ifdef MDU_EARLY_OUT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    typedef struct {
        logic [4:0]  addr;
        logic        en;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_i = 1'b0;
    logic [2:0]  op_i = 3'd0;
    logic [31:0] r1_data_i = 32'd0;
    logic [31:0] r2_data_i = 32'd0;
    logic [4:0]  w_addr_i = 5'd0;
    logic        flush_i = 1'b0;
    logic        stall_req_o, busy_o, done_o, w_enable_o;
    logic [4:0]  w_addr_o;
    logic [31:0] w_data_o;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    exp_t sb[$];
    exp_t mon_e;

    ex_mdu dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .op_i        (op_i),
        .r1_data_i   (r1_data_i),
        .r2_data_i   (r2_data_i),
        .w_addr_i    (w_addr_i),
        .flush_i     (flush_i),
        .stall_req_o (stall_req_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .w_enable_o  (w_enable_o),
        .w_addr_o    (w_addr_o),
        .w_data_o    (w_data_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Waits for the unit to accept, drives one op and records its expected write-back
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] addr, input logic [31:0] exp, input bit early);
        int   n;
        exp_t e;
        n = 0;
        while (busy_o && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("accept_wait", 64'(busy_o), 64'd0);
        start_i   = 1'b1;
        op_i      = op;
        r1_data_i = a;
        r2_data_i = b;
        w_addr_i  = addr;
        e.addr = addr;
        e.en   = (addr != 5'd0);
        e.data = e.en ? exp : 32'd0;
        e.cyc  = cyc + ((EARLY && early) ? 1 : 33);
        sb.push_back(e);
        #1 chk("stall_on_start", 64'(stall_req_o), 64'd1);
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("queue_drained", 64'(sb.size()), 64'd0);
    endtask

    // Monitor: samples just after each rising edge and checks every cycle
    always @(posedge clk) begin
        #1;
        if (!rst) begin
            if (done_o) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 64'(done_o), 64'd0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("writeback", 64'({w_enable_o, w_addr_o, w_data_o}),
                        64'({mon_e.en, mon_e.addr, mon_e.data}));
                    chk("done_cycle", 64'(cyc), 64'(mon_e.cyc));
                    if (!start_i) chk("stall_in_done", 64'(stall_req_o), 64'd0);
                end
            end else begin
                chk("quiet_outputs", 64'({w_enable_o, w_addr_o, w_data_o}), 64'd0);
            end
            if (busy_o) chk("stall_while_busy", 64'(stall_req_o), 64'd1);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_outputs", 64'({stall_req_o, busy_o, done_o, w_enable_o, w_addr_o, w_data_o}), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        run_op(MUL,    32'd7,          32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB, 1'b0);
        run_op(MULHU,  32'hFFFFFFFF,   32'hFFFFFFFF, 5'd6,  32'hFFFFFFFE, 1'b0);
        run_op(MULH,   32'h80000000,   32'h80000000, 5'd7,  32'h40000000, 1'b0);
        run_op(MULHSU, 32'hFFFFFFFF,   32'd2,        5'd8,  32'hFFFFFFFF, 1'b0);
        run_op(MULH,   32'hFFFFFFFF,   32'hFFFFFFFF, 5'd18, 32'h00000000, 1'b0);
        run_op(MULHSU, 32'h80000000,   32'hFFFFFFFF, 5'd19, 32'h80000000, 1'b0);
        run_op(MUL,    32'd0,          32'd5,        5'd17, 32'h00000000, 1'b1);
        run_op(DIV,    32'hFFFFFFF9,   32'd2,        5'd9,  32'hFFFFFFFD, 1'b0);
        run_op(REM,    32'hFFFFFFF9,   32'd2,        5'd10, 32'hFFFFFFFF, 1'b0);
        run_op(DIVU,   32'd5,          32'd0,        5'd11, 32'hFFFFFFFF, 1'b1);
        run_op(REM,    32'h80000000,   32'hFFFFFFFF, 5'd12, 32'h00000000, 1'b1);
        run_op(DIV,    32'h80000000,   32'hFFFFFFFF, 5'd13, 32'h80000000, 1'b1);
        run_op(REM,    32'd7,          32'hFFFFFFFE, 5'd20, 32'h00000001, 1'b0);
        run_op(DIV,    32'd7,          32'hFFFFFFFE, 5'd21, 32'hFFFFFFFD, 1'b0);
        run_op(REMU,   32'd100,        32'd7,        5'd15, 32'h00000002, 1'b0);
        run_op(DIVU,   32'd100,        32'd7,        5'd16, 32'h0000000E, 1'b0);
        run_op(REM,    32'hFFFFFFF9,   32'd0,        5'd22, 32'hFFFFFFF9, 1'b1);
        run_op(DIV,    32'hFFFFFFF9,   32'd0,        5'd23, 32'hFFFFFFFF, 1'b1);
        run_op(MUL,    32'd123,        32'd456,      5'd0,  32'h0000DB18, 1'b0);
        run_op(DIVU,   32'd9,          32'd0,        5'd14, 32'hFFFFFFFF, 1'b1);
        drain();

        // Flush a DIV ten cycles in; it must vanish without a write-back
        start_i   = 1'b1;
        op_i      = DIV;
        r1_data_i = 32'd100;
        r2_data_i = 32'd3;
        w_addr_i  = 5'd3;
        @(negedge clk);
        start_i = 1'b0;
        repeat (9) @(negedge clk);
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        chk("after_flush", 64'({busy_o, done_o, stall_req_o}), 64'd0);
        run_op(MUL,    32'd6,          32'd7,        5'd4,  32'd42,       1'b0);
        drain();
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ex_mdu.md
Name: ex_mdu

Overview:
- Parametrised multi-cycle multiply/divide execute unit (RV M-extension) beside the single-cycle EX ALU in the EX stage.
- Accepts one operation per start pulse and computes iteratively; holds the pipeline through stall_req_o.
- Returns a write-back triple (enable/addr/data) that EX muxes onto its own write-back outputs.

Parameters:
- XLEN, 32, operand/result width; must be even and at least 8.
- MUL_STEP, 1, multiplier bits retired per cycle; must divide XLEN (1, 2, 4).
- REG_AW, 5, register-address width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start_i  in  1  request; sampled only in IDLE or DONE
- op_i  in  3  MDU op code (package encoding)
- r1_data_i  in  XLEN  rs1 operand (multiplicand/dividend)
- r2_data_i  in  XLEN  rs2 operand (multiplier/divisor)
- w_addr_i  in  REG_AW  destination register
- flush_i  in  1  kill the in-flight op (branch taken upstream)
- stall_req_o  out  1  pipeline stall request to ctrl
- busy_o  out  1  state is MUL or DIV
- done_o  out  1  one-cycle result strobe
- w_enable_o  out  1  write enable, valid with done_o
- w_addr_o  out  REG_AW  destination register, valid with done_o
- w_data_o  out  XLEN  result, valid with done_o

Behaviour:
- One clock and a synchronous active-high reset. rst returns to IDLE; all registered outputs are 0.
- rst has priority over flush_i, and flush_i over start_i.
- FSM states: IDLE, MUL, DIV, DONE.
- IDLE/DONE + start_i: latch op, operands, w_addr and sign info. Go to MUL (ops 0-3) or DIV (ops 4-7).
- DONE without start_i: go to IDLE. Back-to-back ops lose no cycle.
- MUL runs XLEN/MUL_STEP cycles; shift-add on magnitudes into a 2*XLEN accumulator.
- DIV runs XLEN cycles; restoring division on magnitudes.
- After the last iteration, go to DONE. Sign correction is registered on the DONE transition.
- Latency from start_i to done_o: XLEN/MUL_STEP+1 cycles (MUL) or XLEN+1 cycles (DIV).
- stall_req_o is combinational = (start_i & (IDLE|DONE)) | MUL | DIV. It is 0 in the DONE cycle so the pipeline advances with the result.
- busy_o and done_o are derived from registered state only.
- Result selection:
  - MUL returns the low XLEN bits.
  - MULH, MULHSU and MULHU return the high XLEN bits, with signedness per op.
  - DIV/DIVU return the quotient; REM/REMU return the remainder.
  - Remainder sign follows the dividend.
- Divide by zero: quotient = all-ones; remainder = dividend. No trap.
- Signed overflow (-2^(XLEN-1) / -1): quotient = dividend; remainder = 0.
- x0 writes: w_enable_o = done_o & (w_addr_o != 0). When that is 0, w_data_o is forced to 0.
- In MUL/DIV, start_i is ignored (busy). flush_i in any state: go to IDLE next cycle, no done_o, outputs cleared.
- The DONE-cycle outputs hold only for that one cycle; they are 0 in all other states.

Optional Feature:
- Macro: MDU_EARLY_OUT_EN.
- When defined, IDLE/DONE + start_i goes directly to DONE (latency 1) in these cases:
  - either operand is zero on a multiply;
  - divisor is zero;
  - signed overflow on a divide.
- The result is produced by the special-case rules above.
- When undefined, every op takes the full iterative latency; results are identical.

Decomposition:
- Shared package: MDU op-code localparams (MUL=0, MULH=1, MULHSU=2, MULHU=3, DIV=4, DIVU=5, REM=6, REMU=7).
- Shared package: FSM state encoding and the XLEN default.
- One natural sub-module: ex_mdu_div_step, the combinational single restoring-division iteration (remainder/quotient in, next remainder/quotient out).

Test Plan:
- XLEN=32, MUL_STEP=1: MUL 7*-3, w_addr=5 -> done_o at cycle 33, w_data=0xFFFFFFEB, w_enable=1, stall_req high in cycles 0-32.
- MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULH 0x80000000*0x80000000 -> 0x40000000; MULHSU -1*2 -> 0xFFFFFFFF.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 5/0 -> 0xFFFFFFFF; REM 0x80000000/-1 -> 0; DIV 0x80000000/-1 -> 0x80000000.
- Flush at cycle 10 of a DIV -> IDLE next cycle, no done_o, stall_req low; new start accepted the following cycle.
- Back-to-back: start_i asserted in the DONE cycle -> second op accepted with zero gap, and the first result is still emitted that cycle. Writes to w_addr=0 -> w_enable_o=0, w_data_o=0.
- With MDU_EARLY_OUT_EN: DIVU 9/0 -> done_o one cycle after start with 0xFFFFFFFF. Without the macro -> done_o at cycle 33 with the same value.
